// File: rtl/operand_capture_if.sv
// Decode-side, forwarder-side and execute-side signals of the operand capture stage.
// The stage itself uses the slave modport; its environment uses the master modport.
interface operand_capture_if #(
    parameter int XLEN        = 32,
    parameter int PAYLOAD_W   = 64,
    parameter int STALL_CNT_W = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic                   in_uses_rs1;
    logic                   in_uses_rs2;
    logic [4:0]             fwd_rs1;
    logic [4:0]             fwd_rs2;
    logic                   fwd1_valid;
    logic                   fwd2_valid;
    logic [XLEN-1:0]        fwd1_value;
    logic [XLEN-1:0]        fwd2_value;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [PAYLOAD_W-1:0]   out_payload;
    logic [XLEN-1:0]        out_op1;
    logic [XLEN-1:0]        out_op2;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport slave (
        input  in_valid, in_payload, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2,
        input  fwd1_valid, fwd2_valid, fwd1_value, fwd2_value, flush, out_ready,
        output in_ready, fwd_rs1, fwd_rs2, out_valid, out_payload, out_op1, out_op2,
        output stall_cycles
    );

    modport master (
        output in_valid, in_payload, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2,
        output fwd1_valid, fwd2_valid, fwd1_value, fwd2_value, flush, out_ready,
        input  in_ready, fwd_rs1, fwd_rs2, out_valid, out_payload, out_op1, out_op2,
        input  stall_cycles
    );
endinterface

// File: rtl/operand_capture_stage.sv
// Stage-3 entry register: holds one decoded instruction, captures its forwarded operands.
// Latency: accept at N, out_valid earliest N+1. Backpressure: in_ready only when empty or firing.
module operand_capture_stage #(
    parameter int XLEN        = 32,
    parameter int PAYLOAD_W   = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    operand_capture_if.slave   bus
);
    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q,   state_d;
    logic                   cap1_q,    cap1_d;
    logic                   cap2_q,    cap2_d;
    logic [XLEN-1:0]        op1_q,     op1_d;
    logic [XLEN-1:0]        op2_q,     op2_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [4:0]             rs1_q,     rs1_d;
    logic [4:0]             rs2_q,     rs2_d;
    logic [STALL_CNT_W-1:0] stall_q,   stall_d;

    logic held;
    logic out_vld;
    logic in_rdy;
    logic fire;
    logic accept;

    always_comb begin
        held    = (state_q == HELD);
        out_vld = held && (cap1_q || bus.fwd1_valid) && (cap2_q || bus.fwd2_valid);
        in_rdy  = !held || (out_vld && bus.out_ready);
        // flush overrides both the hand-off to execute and the intake from decode
        fire    = out_vld && bus.out_ready && !bus.flush;
        accept  = bus.in_valid && in_rdy && !bus.flush;
    end

    always_comb begin
        state_d   = state_q;
        cap1_d    = cap1_q;
        cap2_d    = cap2_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        payload_d = payload_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        stall_d   = stall_q;

        if (bus.flush) begin
            state_d = IDLE;
            cap1_d  = 1'b0;
            cap2_d  = 1'b0;
        end else if (accept) begin
            // unused operands count as captured with value 0 and present rs=0
            state_d   = HELD;
            payload_d = bus.in_payload;
            rs1_d     = bus.in_uses_rs1 ? bus.in_rs1 : 5'd0;
            rs2_d     = bus.in_uses_rs2 ? bus.in_rs2 : 5'd0;
            cap1_d    = !bus.in_uses_rs1;
            cap2_d    = !bus.in_uses_rs2;
            op1_d     = '0;
            op2_d     = '0;
        end else if (fire) begin
            state_d = IDLE;
            cap1_d  = 1'b0;
            cap2_d  = 1'b0;
        end else if (held) begin
            if (!cap1_q && bus.fwd1_valid) begin
                cap1_d = 1'b1;
                op1_d  = bus.fwd1_value;
            end
            if (!cap2_q && bus.fwd2_valid) begin
                cap2_d = 1'b1;
                op2_d  = bus.fwd2_value;
            end
        end

        if (held && !out_vld && !bus.flush && (stall_q != '1)) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cap1_q    <= 1'b0;
            cap2_q    <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            payload_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            cap1_q    <= cap1_d;
            cap2_q    <= cap2_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            payload_q <= payload_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = out_vld;
    assign bus.out_payload  = payload_q;
    assign bus.fwd_rs1      = rs1_q;
    assign bus.fwd_rs2      = rs2_q;
    assign bus.out_op1      = cap1_q ? op1_q : bus.fwd1_value;
    assign bus.out_op2      = cap2_q ? op2_q : bus.fwd2_value;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_operand_capture_stage.sv
// Bench for operand_capture_stage with a 4-bit stall counter so saturation is reachable.
module tb_operand_capture_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_capture_if #(.XLEN(32), .PAYLOAD_W(64), .STALL_CNT_W(4)) bus ();

    operand_capture_stage #(.XLEN(32), .PAYLOAD_W(64), .STALL_CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_payload  = '0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_uses_rs1 = 1'b0;
        bus.in_uses_rs2 = 1'b0;
        bus.fwd1_valid  = 1'b0;
        bus.fwd2_valid  = 1'b0;
        bus.fwd1_value  = '0;
        bus.fwd2_value  = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic offer(input logic [63:0] pay, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2);
        bus.in_valid    = 1'b1;
        bus.in_payload  = pay;
        bus.in_rs1      = r1;
        bus.in_rs2      = r2;
        bus.in_uses_rs1 = u1;
        bus.in_uses_rs2 = u2;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.fwd_rs1 !== 5'd0 || bus.fwd_rs2 !== 5'd0) begin errors++; $display("FAIL reset_fwd_rs got=%0d/%0d exp=0/0", bus.fwd_rs1, bus.fwd_rs2); end
        checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        offer(64'hA5, 5'd3, 5'd4, 1'b1, 1'b1);
        bus.fwd1_valid = 1'b1; bus.fwd1_value = 32'h10;
        bus.fwd2_valid = 1'b1; bus.fwd2_value = 32'h20;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nohaz_accept_cycle_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nohaz_valid_n1 got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.out_op1 !== 32'h10 || bus.out_op2 !== 32'h20) begin errors++; $display("FAIL nohaz_ops got=%h/%h exp=10/20", bus.out_op1, bus.out_op2); end
        checks++; if (bus.out_payload !== 64'hA5) begin errors++; $display("FAIL nohaz_payload got=%h exp=a5", bus.out_payload); end
        checks++; if (bus.fwd_rs1 !== 5'd3 || bus.fwd_rs2 !== 5'd4) begin errors++; $display("FAIL nohaz_fwd_rs got=%0d/%0d exp=3/4", bus.fwd_rs1, bus.fwd_rs2); end
        bus.out_ready = 1'b1;
        // back-to-back stream of 8 while the previous one drains
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 8) offer(64'd100 + 64'(i), 5'd1, 5'd2, 1'b1, 1'b1);
            else bus.in_valid = 1'b0;
            bus.fwd1_value = 32'h1000 + 32'(i);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, bus.in_ready); end
            if (i > 0) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_payload !== 64'd100 + 64'(i - 1)) begin errors++; $display("FAIL b2b_out[%0d] got=%0b/%0d exp=1/%0d", i, bus.out_valid, bus.out_payload, 100 + i - 1); end
                checks++; if (bus.out_op1 !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL b2b_op1[%0d] got=%h exp=%h", i, bus.out_op1, 32'h1000 + i); end
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        offer(64'hB1, 5'd5, 5'd6, 1'b1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.fwd2_valid = 1'b1; bus.fwd2_value = 32'h7;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_stall1_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        bus.fwd2_valid = 1'b0; bus.fwd2_value = 32'h99;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_stall2_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        bus.fwd1_valid = 1'b1; bus.fwd1_value = 32'hDEAD;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lu_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.out_op1 !== 32'hDEAD || bus.out_op2 !== 32'h7) begin errors++; $display("FAIL lu_ops got=%h/%h exp=dead/7", bus.out_op1, bus.out_op2); end
        checks++; if (bus.stall_cycles !== 4'd2) begin errors++; $display("FAIL lu_stall_cycles got=%0d exp=2", bus.stall_cycles); end
    endtask

    task automatic test_unused_operand();
        do_reset();
        offer(64'hC0, 5'd8, 5'd9, 1'b1, 1'b0);
        bus.fwd1_valid = 1'b1; bus.fwd1_value = 32'h55;
        bus.fwd2_value = 32'hFFFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL unused_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.out_op2 !== 32'h0 || bus.out_op1 !== 32'h55) begin errors++; $display("FAIL unused_ops got=%h/%h exp=55/0", bus.out_op1, bus.out_op2); end
        checks++; if (bus.fwd_rs2 !== 5'd0) begin errors++; $display("FAIL unused_fwd_rs2 got=%0d exp=0", bus.fwd_rs2); end
        checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL unused_stall got=%0d exp=0", bus.stall_cycles); end
    endtask

    task automatic test_backpressure();
        do_reset();
        offer(64'hC3, 5'd1, 5'd2, 1'b1, 1'b1);
        bus.fwd1_valid = 1'b1; bus.fwd1_value = 32'h11;
        bus.fwd2_valid = 1'b1; bus.fwd2_value = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            offer(64'hD4, 5'd3, 5'd4, 1'b1, 1'b1);
            if (i > 0) begin bus.fwd1_value = 32'hBAD; bus.fwd2_value = 32'hBAD; end
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%0b r=%0b exp v=1 r=0", i, bus.out_valid, bus.in_ready); end
            checks++; if (bus.out_payload !== 64'hC3 || bus.out_op1 !== 32'h11 || bus.out_op2 !== 32'h22) begin errors++; $display("FAIL bp_stable[%0d] got=%h/%h/%h exp=c3/11/22", i, bus.out_payload, bus.out_op1, bus.out_op2); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.fwd1_value = 32'h33; bus.fwd2_value = 32'h44;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_payload !== 64'hC3) begin errors++; $display("FAIL bp_release got r=%0b pay=%h exp r=1 pay=c3", bus.in_ready, bus.out_payload); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_payload !== 64'hD4 || bus.out_op1 !== 32'h33) begin errors++; $display("FAIL bp_next got v=%0b pay=%h op1=%h exp 1/d4/33", bus.out_valid, bus.out_payload, bus.out_op1); end
    endtask

    task automatic test_flush();
        do_reset();
        offer(64'hE5, 5'd7, 5'd8, 1'b1, 1'b1);
        bus.fwd2_valid = 1'b1; bus.fwd2_value = 32'h1;
        @(negedge clk);
        offer(64'hF6, 5'd9, 5'd10, 1'b1, 1'b1);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.fwd1_valid = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got v=%0b r=%0b exp v=0 r=1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL flush_stall got=%0d exp=0", bus.stall_cycles); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        offer(64'h77, 5'd11, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        end
        #1;
        checks++; if (bus.stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_count got=%0d exp=15", bus.stall_cycles); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL midreset got v=%0b r=%0b s=%0d exp 0/1/0", bus.out_valid, bus.in_ready, bus.stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_random();
        bit              m_held = 1'b0, m_h1 = 1'b0, m_h2 = 1'b0;
        logic [63:0]     m_pay = '0;
        logic [4:0]      m_rs1 = '0, m_rs2 = '0;
        logic [31:0]     m_v1 = '0, m_v2 = '0;
        int              m_stall = 0;
        bit              e_valid, e_ready;
        logic [31:0]     e_op1, e_op2;
        int              e_stall;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid    = ($urandom_range(0, 9) < 6);
            bus.in_payload  = {$urandom, $urandom};
            bus.in_rs1      = 5'($urandom);
            bus.in_rs2      = 5'($urandom);
            bus.in_uses_rs1 = ($urandom_range(0, 3) != 0);
            bus.in_uses_rs2 = ($urandom_range(0, 3) != 0);
            bus.fwd1_valid  = $urandom_range(0, 1) == 1;
            bus.fwd2_valid  = $urandom_range(0, 1) == 1;
            bus.fwd1_value  = $urandom;
            bus.fwd2_value  = $urandom;
            bus.flush       = ($urandom_range(0, 19) == 0);
            bus.out_ready   = ($urandom_range(0, 9) < 7);
            #1;
            e_valid = m_held && (m_h1 || bus.fwd1_valid) && (m_h2 || bus.fwd2_valid);
            e_ready = !m_held || (e_valid && bus.out_ready);
            e_op1   = m_h1 ? m_v1 : bus.fwd1_value;
            e_op2   = m_h2 ? m_v2 : bus.fwd2_value;
            e_stall = (m_stall > 15) ? 15 : m_stall;
            checks++; if (bus.out_valid !== e_valid || bus.in_ready !== e_ready) begin errors++; $display("FAIL rnd_hs[%0d] got v=%0b r=%0b exp v=%0b r=%0b", c, bus.out_valid, bus.in_ready, e_valid, e_ready); end
            checks++; if (bus.stall_cycles !== 4'(e_stall)) begin errors++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", c, bus.stall_cycles, e_stall); end
            if (m_held) begin
                checks++; if (bus.fwd_rs1 !== m_rs1 || bus.fwd_rs2 !== m_rs2) begin errors++; $display("FAIL rnd_rs[%0d] got=%0d/%0d exp=%0d/%0d", c, bus.fwd_rs1, bus.fwd_rs2, m_rs1, m_rs2); end
            end
            if (e_valid) begin
                checks++; if (bus.out_payload !== m_pay || bus.out_op1 !== e_op1 || bus.out_op2 !== e_op2) begin errors++; $display("FAIL rnd_data[%0d] got=%h/%h/%h exp=%h/%h/%h", c, bus.out_payload, bus.out_op1, bus.out_op2, m_pay, e_op1, e_op2); end
            end
            // advance the reference across the coming clock edge
            if (m_held && !e_valid && !bus.flush) m_stall++;
            if (bus.flush) begin
                m_held = 1'b0;
            end else if (bus.in_valid && e_ready) begin
                m_held = 1'b1; m_pay = bus.in_payload;
                m_rs1 = bus.in_uses_rs1 ? bus.in_rs1 : 5'd0;
                m_rs2 = bus.in_uses_rs2 ? bus.in_rs2 : 5'd0;
                m_h1 = !bus.in_uses_rs1; m_v1 = '0;
                m_h2 = !bus.in_uses_rs2; m_v2 = '0;
            end else if (e_valid && bus.out_ready) begin
                m_held = 1'b0;
            end else if (m_held) begin
                if (!m_h1 && bus.fwd1_valid) begin m_h1 = 1'b1; m_v1 = bus.fwd1_value; end
                if (!m_h2 && bus.fwd2_valid) begin m_h2 = 1'b1; m_v2 = bus.fwd2_value; end
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_no_hazard();
        test_load_use();
        test_unused_operand();
        test_backpressure();
        test_flush();
        test_saturation_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
